alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter that shares the single registered ALU between two requesters (e.g. the execute stage and the branch/address unit). It accepts at most one operation per cycle over valid/ready handshakes and drives the ALU operand and opcode inputs from registers. It tracks each operation through the ALU's one-cycle latency and returns the result and zero flag to the requester that issued it. Unsupported opcodes are trapped before they reach the ALU.

## Interface
- WIDTH, 32, operand/result width
- OPW, 4, opcode width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_data0, req0_data1 / req1_data0, req1_data1  in  WIDTH  operands
- req0_op / req1_op  in  OPW  ALU opcode
- alu_data0, alu_data1  out  WIDTH  registered operands to ALU
- alu_operation  out  OPW  registered opcode to ALU
- alu_result  in  WIDTH  ALU result (registered inside ALU)
- alu_zero  in  1  ALU zero flag (data0 == data1, independent of opcode)
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse; no backpressure
- rsp0_result / rsp1_result  out  WIDTH  result
- rsp0_zero / rsp1_zero  out  1  zero flag
- rsp0_err / rsp1_err  out  1  opcode was illegal

## Operation
- Legal opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 MIN (unsigned), 12 NOR. Every other value is illegal.
- Grant, evaluated each cycle (combinational):
  - No valid request → no grant.
  - One valid request → that requester is granted.
  - Both valid → arbitration policy applies (see Configuration).
- reqX_ready = grantX. Handshake completes when valid && ready. Requester must hold op and data stable while valid and not ready.
- On a legal accept:
  - Operands and opcode are loaded into alu_data0/alu_data1/alu_operation.
  - Stage-1 tag is set: valid=1, id=X, err=0.
- On an illegal accept:
  - alu_* registers hold their previous values.
  - Stage-1 tag is set: valid=1, id=X, err=1.
- No accept: alu_* hold; stage-1 valid=0.
- Stage-1 tag advances to stage 2 every cycle, unconditionally.
- When stage-2 valid=1, rsp{id}_valid=1 and the other port's rsp_valid=0:
  - rsp_result = alu_result, rsp_zero = alu_zero, rsp_err = 0.
  - If err: result = 0, zero = 0, err = 1.
- Outputs of the non-responding port: valid=0, result/zero/err=0.
- Throughput: one op per cycle. Responses return in acceptance order.

## Timing
- Latency 2: accepted in cycle N → rsp valid in cycle N+2. Illegal ops use the same latency so ordering is preserved.
- Back-to-back accepts in N and N+1 give responses in N+2 and N+3, possibly on different ports.
- Reset (rst=1 at an edge):
  - Stage-1/2 valid cleared; in-flight operations are dropped with no response.
  - alu_data0, alu_data1, alu_operation = 0; round-robin pointer = requester 0.
  - All rsp outputs = 0.
  - reqX_ready = 0 while rst is high.
- First accept possible in the first cycle with rst low.
- Simultaneous accept and response in the same cycle is normal pipelined operation; no stall.

## Configuration
- ALU_ARB_RR_EN defined: round-robin.
  - On contention, grant the requester not granted at the last accept.
  - A 1-bit pointer updates only on accept.
  - After reset, requester 0 wins the first contention.
- Not defined: fixed priority. Requester 0 always wins contention, and no pointer register exists. Requester 1 can starve.

## Test plan
- Single op: req0 ADD 5+7 in cycle N → rsp0_valid in N+2, result 12, zero 0, err 0; rsp1_valid stays 0.
- Zero flag: req1 SUB 9,9 → rsp1 result 0, zero 1. Then req1 OR 3,3 → result 3, zero 1 (zero tracks operand equality, not result).
- Illegal op: req0 op 5 with operands 1,2 → rsp0 in N+2 with err 1, result 0. alu_operation unchanged from the previous legal op.
- Contention with ALU_ARB_RR_EN, both valid for 4 cycles → grants alternate 0,1,0,1; responses alternate ports with 2-cycle latency. Without the macro → req0 granted all 4 cycles, req1_ready stays 0.
- Back-to-back then reset:
  - req0 AND 0xF0,0x3C; req1 NOR 0,0; req0 MIN 4,9 in consecutive cycles → 0x30, 0xFFFFFFFF, 4 in order.
  - Repeat, asserting rst in the cycle after the third accept → no further responses; alu_* read 0 after reset.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of a single registered ALU; tags ops through the ALU latency.
// Optional macro ALU_ARB_RR_EN selects round-robin contention; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data0,
  input  logic [WIDTH-1:0] req0_data1,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data0,
  input  logic [WIDTH-1:0] req1_data1,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_data0,
  output logic [WIDTH-1:0] alu_data1,
  output logic [OPW-1:0]   alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  logic             w_gnt0, w_gnt1, w_acc, w_id, w_legal;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_d0, w_d1;
  logic             r_s1_vld, r_s1_id, r_s1_err;
  logic             r_s2_vld, r_s2_id, r_s2_err;
  logic [WIDTH-1:0] r_alu_d0, r_alu_d1;
  logic [OPW-1:0]   r_alu_op;

`ifdef ALU_ARB_RR_EN
  // r_ptr names the requester that wins the next contention.
  logic r_ptr;
  assign w_gnt1 = req1_valid && (!req0_valid || r_ptr);

  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= 1'b0;
    else if (w_acc) r_ptr <= ~w_id;
  end
`else
  assign w_gnt1 = req1_valid && !req0_valid;
`endif
  assign w_gnt0 = req0_valid && !w_gnt1;

  assign req0_ready = w_gnt0 && !rst;
  assign req1_ready = w_gnt1 && !rst;
  assign w_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_id       = req1_ready;
  assign w_op       = w_id ? req1_op    : req0_op;
  assign w_d0       = w_id ? req1_data0 : req0_data0;
  assign w_d1       = w_id ? req1_data1 : req0_data1;

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OPW'(0), OPW'(1), OPW'(2), OPW'(6), OPW'(7), OPW'(12): w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal ops still occupy a pipeline slot so responses stay in acceptance order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= 1'b0;
      r_s1_err <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= 1'b0;
      r_s2_err <= 1'b0;
      r_alu_d0 <= '0;
      r_alu_d1 <= '0;
      r_alu_op <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s1_id  <= w_id;
      r_s1_err <= w_acc && !w_legal;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      r_s2_err <= r_s1_err;
      if (w_acc && w_legal) begin
        r_alu_d0 <= w_d0;
        r_alu_d1 <= w_d1;
        r_alu_op <= w_op;
      end
    end
  end

  assign alu_data0     = r_alu_d0;
  assign alu_data1     = r_alu_d1;
  assign alu_operation = r_alu_op;

  assign rsp0_valid  = r_s2_vld && !r_s2_id;
  assign rsp1_valid  = r_s2_vld &&  r_s2_id;
  assign rsp0_result = (rsp0_valid && !r_s2_err) ? alu_result : '0;
  assign rsp1_result = (rsp1_valid && !r_s2_err) ? alu_result : '0;
  assign rsp0_zero   = rsp0_valid && !r_s2_err && alu_zero;
  assign rsp1_zero   = rsp1_valid && !r_s2_err && alu_zero;
  assign rsp0_err    = rsp0_valid && r_s2_err;
  assign rsp1_err    = rsp1_valid && r_s2_err;

endmodule
